// File: rtl/latch_drv_pkg.sv
// Shared types and constants for the latch_drv write sequencer.
package latch_drv_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // A phase of n cycles loads n-1 so the timer reads zero in its last cycle.
  function automatic logic [CNT_W-1:0] cyc_to_ld(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/latch_drv_timer.sv
// Window timer: 4-bit down-counter, loaded on phase entry, saturating at zero.
module latch_drv_timer
  import latch_drv_pkg::*;
(
  input  logic             CK,
  input  logic             RN,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/latch_drv.sv
// Drives a DLH latch bank: D set up, G pulsed high for a fixed window, then held.
// Optional readback checking of latch Q enabled by LATCH_DRV_READBACK_EN.
module latch_drv
  import latch_drv_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 2
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] lat_d,
  output logic         lat_g,
  output logic         done,
  output logic         err
`ifdef LATCH_DRV_READBACK_EN
  ,
  input  logic [W-1:0] q_fb
`endif
);

  localparam logic [CNT_W-1:0] SETUP_LD  = cyc_to_ld(SETUP_CYC);
  localparam logic [CNT_W-1:0] OPEN_LD   = cyc_to_ld(OPEN_CYC);
  localparam bit               HAS_SETUP = (SETUP_CYC != 0);

  state_t           state, state_nxt;
  logic             xfer;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_ld_val;
  logic [CNT_W-1:0] tmr_val_unused;
  logic             tmr_zero;

  assign xfer = (state == IDLE) && in_valid;

  latch_drv_timer u_timer (
    .CK       (CK),
    .RN       (RN),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .value    (tmr_val_unused),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tmr_load   = 1'b0;
    tmr_ld_val = OPEN_LD;
    case (state)
      IDLE: begin
        if (in_valid) begin
          tmr_load = 1'b1;
          if (HAS_SETUP) begin
            state_nxt  = SETUP;
            tmr_ld_val = SETUP_LD;
          end else begin
            state_nxt  = OPEN;
          end
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_nxt = OPEN;
          tmr_load  = 1'b1;
        end
      end
      OPEN: begin
        if (tmr_zero) begin
          state_nxt = HOLD;
        end
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    done     = (state == HOLD);
  end

  // G is decoded from the next state and registered so it never glitches.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      lat_g <= 1'b0;
      lat_d <= '0;
    end else begin
      lat_g <= (state_nxt == OPEN);
      if (xfer) begin
        lat_d <= in_data;
      end
    end
  end

`ifdef LATCH_DRV_READBACK_EN
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      err <= 1'b0;
    end else if ((state == HOLD) && (q_fb != lat_d)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_drv.sv
// Directed self-checking bench for latch_drv (default and SETUP_CYC=0/OPEN_CYC=1 builds).
module tb_latch_drv;

  logic       CK;
  logic       RN;
  logic       in_valid0, in_valid1;
  logic [7:0] in_data0, in_data1;
  logic       in_ready0, in_ready1;
  logic [7:0] lat_d0, lat_d1;
  logic       lat_g0, lat_g1;
  logic       done0, done1;
  logic       err0, err1;
`ifdef LATCH_DRV_READBACK_EN
  logic [7:0] qfb;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  latch_drv #(.W(8), .SETUP_CYC(1), .OPEN_CYC(2)) u0 (
    .CK       (CK),
    .RN       (RN),
    .in_valid (in_valid0),
    .in_ready (in_ready0),
    .in_data  (in_data0),
    .lat_d    (lat_d0),
    .lat_g    (lat_g0),
    .done     (done0),
    .err      (err0)
`ifdef LATCH_DRV_READBACK_EN
    ,
    .q_fb     (qfb)
`endif
  );

  latch_drv #(.W(8), .SETUP_CYC(0), .OPEN_CYC(1)) u1 (
    .CK       (CK),
    .RN       (RN),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_data  (in_data1),
    .lat_d    (lat_d1),
    .lat_g    (lat_g1),
    .done     (done1),
    .err      (err1)
`ifdef LATCH_DRV_READBACK_EN
    ,
    .q_fb     (lat_d1)
`endif
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic [7:0] exp_d;
    logic       exp_g;
    logic       exp_rdy;
    logic       exp_done;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CK);
  endtask

`ifdef LATCH_DRV_READBACK_EN
  // Accept one word, advance to the HOLD cycle (cycle 4).
  task automatic write_to_hold(input logic [7:0] d, input logic [7:0] q);
    qfb       = q;
    in_valid0 = 1'b1;
    in_data0  = d;
    step();
    in_valid0 = 1'b0;
    repeat (3) step();
  endtask
`endif

  initial begin
    RN = 1'b0;
    in_valid0 = 1'b0; in_data0 = 8'h00;
    in_valid1 = 1'b0; in_data1 = 8'h00;
`ifdef LATCH_DRV_READBACK_EN
    qfb = 8'h00;
`endif

    //            iv    din    lat_d  g     rdy   done
    vt[0]  = '{1'b1, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 8'hEE, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'hEE, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'hEE, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 8'hEE, 8'hA5, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 8'h11, 8'hA5, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h22, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 8'h22, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 8'h22, 8'h11, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b1, 8'h22, 8'h11, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 8'hEE, 8'h22, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'hEE, 8'h22, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 8'hEE, 8'h22, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 8'hEE, 8'h22, 1'b0, 1'b0, 1'b1};
    vt[15] = '{1'b0, 8'hEE, 8'h22, 1'b0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 8'hEE, 8'h22, 1'b0, 1'b1, 1'b0};

    // Reset held, then released with in_valid low.
    #12;
    chk("rst_lat_g", 32'(lat_g0), 32'h0);
    chk("rst_lat_d", 32'(lat_d0), 32'h00);
    chk("rst_done",  32'(done0),  32'h0);
    chk("rst_err",   32'(err0),   32'h0);
    step();
    RN = 1'b1;
    chk("idle_ready", 32'(in_ready0), 32'h1);
    chk("idle_err",   32'(err0),      32'h0);

    // Single write followed by back-to-back words with in_valid held high.
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("v%0d_lat_d", i), 32'(lat_d0),    32'(vt[i].exp_d));
      chk($sformatf("v%0d_lat_g", i), 32'(lat_g0),    32'(vt[i].exp_g));
      chk($sformatf("v%0d_ready", i), 32'(in_ready0), 32'(vt[i].exp_rdy));
      chk($sformatf("v%0d_done",  i), 32'(done0),     32'(vt[i].exp_done));
      chk($sformatf("v%0d_err",   i), 32'(err0),      32'h0);
      in_valid0 = vt[i].iv;
      in_data0  = vt[i].din;
`ifdef LATCH_DRV_READBACK_EN
      qfb = vt[i].exp_d;
`endif
      step();
    end
    in_valid0 = 1'b0;

    // Reset mid-OPEN: G must drop without a clock edge.
    in_valid0 = 1'b1;
    in_data0  = 8'h5A;
    step();
    in_valid0 = 1'b0;
    step();
    chk("mid_open_g_before", 32'(lat_g0), 32'h1);
    chk("mid_open_d_before", 32'(lat_d0), 32'h5A);
    #2 RN = 1'b0;
    #1;
    chk("async_rst_g",     32'(lat_g0),    32'h0);
    chk("async_rst_d",     32'(lat_d0),    32'h00);
    chk("async_rst_ready", 32'(in_ready0), 32'h1);
    chk("async_rst_done",  32'(done0),     32'h0);
    step();
    RN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("post_rst%0d_ready", i), 32'(in_ready0), 32'h1);
      chk($sformatf("post_rst%0d_done",  i), 32'(done0),     32'h0);
      chk($sformatf("post_rst%0d_g",     i), 32'(lat_g0),    32'h0);
      step();
    end

`ifdef LATCH_DRV_READBACK_EN
    // Readback: good write, bad write sets sticky err, good write keeps it.
    write_to_hold(8'h3C, 8'h3C);
    chk("rb_good_hold_err", 32'(err0), 32'h0);
    step();
    chk("rb_good_after_err", 32'(err0), 32'h0);
    write_to_hold(8'h3C, 8'h3D);
    chk("rb_bad_hold_err", 32'(err0), 32'h0);
    step();
    chk("rb_bad_after_err", 32'(err0), 32'h1);
    write_to_hold(8'h77, 8'h77);
    chk("rb_sticky_hold_err", 32'(err0), 32'h1);
    step();
    chk("rb_sticky_after_err", 32'(err0), 32'h1);
    #2 RN = 1'b0;
    #1;
    chk("rb_rst_err", 32'(err0), 32'h0);
    step();
    RN = 1'b1;
`endif

    // SETUP_CYC=0, OPEN_CYC=1 instance.
    chk("z_c0_ready", 32'(in_ready1), 32'h1);
    in_valid1 = 1'b1;
    in_data1  = 8'hFF;
    step();
    in_valid1 = 1'b0;
    in_data1  = 8'h00;
    chk("z_c1_lat_d", 32'(lat_d1),    32'hFF);
    chk("z_c1_lat_g", 32'(lat_g1),    32'h1);
    chk("z_c1_ready", 32'(in_ready1), 32'h0);
    chk("z_c1_done",  32'(done1),     32'h0);
    step();
    chk("z_c2_lat_g", 32'(lat_g1),    32'h0);
    chk("z_c2_done",  32'(done1),     32'h1);
    chk("z_c2_ready", 32'(in_ready1), 32'h0);
    step();
    chk("z_c3_ready", 32'(in_ready1), 32'h1);
    chk("z_c3_done",  32'(done1),     32'h0);
    chk("z_c3_lat_d", 32'(lat_d1),    32'hFF);
    chk("z_c3_err",   32'(err1),      32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latch_drv.md
LATCH_DRV -- requirements
Module: latch_drv

Interface
REQ-001 SHALL have parameter W, default 8, meaning the data width driven into the downstream DLH latch bank.
REQ-002 SHALL have parameter SETUP_CYC, default 1, range 0..15, meaning the cycles D is held stable before G rises.
REQ-003 SHALL have parameter OPEN_CYC, default 2, range 1..15, meaning the cycles G is held high (transparent window).
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- CK  input  1  clock; all state changes on its rising edge.
- RN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have the following data and control ports:
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word.
- in_data  input  W  upstream word.
- lat_d  output  W  drives latch D inputs.
- lat_g  output  1  drives latch G inputs (active-high transparent).
- done  output  1  one-cycle pulse when a write completes.
- err  output  1  sticky readback mismatch flag (see REQ-020).
REQ-006 SHALL add port q_fb (input, W bits, latch Q feedback) only when LATCH_DRV_READBACK_EN is defined.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, OPEN and HOLD.
REQ-008 in_ready SHALL be 1 in IDLE only (combinational from state); a transfer occurs on a rising CK with in_valid=1 and in_ready=1.
REQ-009 On transfer, in_data SHALL be registered into lat_d in the same edge; next state SHALL be SETUP if SETUP_CYC>0, else OPEN.
REQ-010 SETUP SHALL last exactly SETUP_CYC cycles with lat_g=0 and lat_d stable.
REQ-011 OPEN SHALL last exactly OPEN_CYC cycles with lat_g=1 and lat_d stable; lat_g SHALL be a registered output (glitch-free).
REQ-012 HOLD SHALL last exactly 1 cycle with lat_g=0 and lat_d stable; done SHALL be 1 during HOLD only; HOLD->IDLE unconditionally.
REQ-013 lat_d SHALL change only on a transfer edge and otherwise retain its last value, including across IDLE.
REQ-014 A single 4-bit down-counter SHALL time SETUP and OPEN, loaded on state entry; it SHALL not wrap and SHALL be ignored in IDLE/HOLD.
REQ-015 in_valid SHALL be ignored outside IDLE; it is held, not dropped, and accepted on the first IDLE cycle.
REQ-016 Accept-to-next-ready latency SHALL be SETUP_CYC+OPEN_CYC+2 cycles; back-to-back words SHALL be separated by exactly that amount.

Reset
REQ-017 RN=0 SHALL asynchronously force state=IDLE, lat_g=0, lat_d=0, done=0, err=0 and counter=0, so that in_ready=1 once RN=1.
REQ-018 Reset asserted mid-OPEN SHALL drop lat_g to 0 immediately, without waiting for CK.

Configuration
REQ-019 Without LATCH_DRV_READBACK_EN defined, q_fb SHALL be absent and err SHALL be constant 0.
REQ-020 With LATCH_DRV_READBACK_EN defined, in HOLD q_fb SHALL be compared against lat_d; on mismatch err SHALL set at that edge and stay 1 until RN.

Structure
REQ-021 The state enum (IDLE/SETUP/OPEN/HOLD) and the counter width constant (4) SHALL live in shared package latch_drv_pkg.
REQ-022 The window timer SHALL be one sub-module, latch_drv_timer (load, value, zero flag); everything else is flat.

Verification (W=8, SETUP_CYC=1, OPEN_CYC=2)
REQ-023 Reset then idle: RN low then high with in_valid=0 -> lat_g=0, lat_d=0x00, in_ready=1, done=0, err=0.
REQ-024 Single write: in_data=0xA5 accepted at cycle 0 -> lat_d=0xA5 from cycle 1; lat_g=1 in cycles 2-3 only; done=1 in cycle 4; in_ready=1 at cycle 5.
REQ-025 Back-to-back: in_valid held high with 0x11 then 0x22 -> second accept exactly 5 cycles after the first; lat_d never changes while lat_g=1.
REQ-026 Reset mid-OPEN: RN low during cycle 2 -> lat_g=0 asynchronously, lat_d=0x00; after release in_ready=1 and no done pulse.
REQ-027 With LATCH_DRV_READBACK_EN, write 0x3C with q_fb=0x3C -> err=0; write 0x3C with q_fb=0x3D -> err=1 from the HOLD edge, persisting through later good writes until RN.
REQ-028 SETUP_CYC=0, OPEN_CYC=1: accept 0xFF -> lat_g=1 in cycle 1, done in cycle 2, ready in cycle 3.
